// File: rtl/xor_stream_arbiter_if.sv
// ---------------------------------------------------------------------------
// xor_stream_arbiter_if
// Bundles the key write port, the two requester streams, the ciphertext
// output stream and the per-channel byte counters of xor_stream_arbiter.
//   key_we/key_sel/key_in     : key write port (key_sel 0 = A, 1 = B)
//   a_valid/a_data/a_ready    : channel A plaintext stream
//   b_valid/b_data/b_ready    : channel B plaintext stream
//   out_valid/out_data/out_src/out_ready : ciphertext stream (out_src 0 = A)
//   cnt_a/cnt_b               : bytes accepted per channel, modulo 256
// Modport slave is the arbiter side; master is the environment side.
// ---------------------------------------------------------------------------
interface xor_stream_arbiter_if #(
    parameter int unsigned WIDTH = 8
);
    logic             key_we;
    logic             key_sel;
    logic [WIDTH-1:0] key_in;

    logic             a_valid;
    logic [WIDTH-1:0] a_data;
    logic             a_ready;

    logic             b_valid;
    logic [WIDTH-1:0] b_data;
    logic             b_ready;

    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_src;
    logic             out_ready;

    logic [7:0]       cnt_a;
    logic [7:0]       cnt_b;

    modport slave (
        input  key_we, key_sel, key_in,
        input  a_valid, a_data, b_valid, b_data, out_ready,
        output a_ready, b_ready, out_valid, out_data, out_src, cnt_a, cnt_b
    );

    modport master (
        output key_we, key_sel, key_in,
        output a_valid, a_data, b_valid, b_data, out_ready,
        input  a_ready, b_ready, out_valid, out_data, out_src, cnt_a, cnt_b
    );
endinterface

// File: rtl/xor_stream_arbiter.sv
// ---------------------------------------------------------------------------
// xor_stream_arbiter
// Round-robin scheduler for two byte streams sharing one XOR unit. Each
// accepted byte is XORed with its channel's rolling key (rotated left by one
// after every byte) and lands in a one-entry registered output stage.
// Ports:
//   clk  : single clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : xor_stream_arbiter_if.slave (key port, A/B streams, output, counters)
// ---------------------------------------------------------------------------
module xor_stream_arbiter #(
    parameter int unsigned WIDTH = 8
) (
    input logic                clk,
    input logic                rst,
    xor_stream_arbiter_if.slave bus
);

    logic [WIDTH-1:0] key_a_q, key_a_d;
    logic [WIDTH-1:0] key_b_q, key_b_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_src_q, out_src_d;
    logic             last_q, last_d;   // 0 = A, 1 = B granted most recently
    logic [7:0]       cnt_a_q, cnt_a_d;
    logic [7:0]       cnt_b_q, cnt_b_d;

    logic free;
    logic grant_a;
    logic grant_b;

    // Grant depends only on valids, the pointer and slot state, never on data.
    always_comb begin
        free    = !out_valid_q || bus.out_ready;
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!rst && free) begin
            if (bus.a_valid && bus.b_valid) begin
                if (last_q) grant_a = 1'b1;
                else        grant_b = 1'b1;
            end else if (bus.a_valid) begin
                grant_a = 1'b1;
            end else if (bus.b_valid) begin
                grant_b = 1'b1;
            end
        end
    end

    always_comb begin
        key_a_d     = key_a_q;
        key_b_d     = key_b_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        last_d      = last_q;
        cnt_a_d     = cnt_a_q;
        cnt_b_d     = cnt_b_q;

        if (grant_a) begin
            out_data_d  = bus.a_data ^ key_a_q;
            out_src_d   = 1'b0;
            out_valid_d = 1'b1;
            last_d      = 1'b0;
            key_a_d     = {key_a_q[WIDTH-2:0], key_a_q[WIDTH-1]};
            cnt_a_d     = cnt_a_q + 8'd1;
        end else if (grant_b) begin
            out_data_d  = bus.b_data ^ key_b_q;
            out_src_d   = 1'b1;
            out_valid_d = 1'b1;
            last_d      = 1'b1;
            key_b_d     = {key_b_q[WIDTH-2:0], key_b_q[WIDTH-1]};
            cnt_b_d     = cnt_b_q + 8'd1;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        // A key write overrides the rotation; the granted byte above already
        // used the old key.
        if (bus.key_we) begin
            if (bus.key_sel) key_b_d = bus.key_in;
            else             key_a_d = bus.key_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_a_q     <= '0;
            key_b_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= 1'b0;
            last_q      <= 1'b1;
            cnt_a_q     <= 8'd0;
            cnt_b_q     <= 8'd0;
        end else begin
            key_a_q     <= key_a_d;
            key_b_q     <= key_b_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            last_q      <= last_d;
            cnt_a_q     <= cnt_a_d;
            cnt_b_q     <= cnt_b_d;
        end
    end

    assign bus.a_ready   = grant_a;
    assign bus.b_ready   = grant_b;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;
    assign bus.cnt_a     = cnt_a_q;
    assign bus.cnt_b     = cnt_b_q;

endmodule

// File: tb/tb_xor_stream_arbiter.sv
// ---------------------------------------------------------------------------
// tb_xor_stream_arbiter
// Directed bench for xor_stream_arbiter. Inputs change on the falling edge,
// readies are sampled 1 ns later, registered outputs 1 ns after the rising
// edge.
// ---------------------------------------------------------------------------
module tb_xor_stream_arbiter;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    xor_stream_arbiter_if #(.WIDTH(8)) bus ();

    xor_stream_arbiter #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus.key_we    = 1'b0;
        bus.key_sel   = 1'b0;
        bus.key_in    = 8'h00;
        bus.a_valid   = 1'b0;
        bus.a_data    = 8'h00;
        bus.b_valid   = 1'b0;
        bus.b_data    = 8'h00;
        bus.out_ready = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic load_key(input logic sel, input logic [7:0] val);
        @(negedge clk);
        bus.key_we  = 1'b1;
        bus.key_sel = sel;
        bus.key_in  = val;
        @(posedge clk);
        #1;
        bus.key_we  = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        idle_inputs();
        rst         = 1'b1;
        bus.a_valid = 1'b1;
        bus.b_valid = 1'b1;
        #1;
        total++;
        if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_readies: got a=%b b=%b want 0 0", bus.a_ready, bus.b_ready);
        end
        @(posedge clk);
        #1;
        total++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || bus.out_src !== 1'b0) begin
            bad++;
            $display("FAIL reset_out: got v=%b d=%h s=%b want 0 00 0",
                     bus.out_valid, bus.out_data, bus.out_src);
        end
        total++;
        if (bus.cnt_a !== 8'd0 || bus.cnt_b !== 8'd0) begin
            bad++;
            $display("FAIL reset_cnt: got a=%0d b=%0d want 0 0", bus.cnt_a, bus.cnt_b);
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    task automatic test_rolling_key();
        logic [7:0] exp_out [3];
        logic [7:0] din     [3];
        exp_out[0] = 8'h5A; exp_out[1] = 8'h4B; exp_out[2] = 8'h3C;
        din[0]     = 8'h55; din[1]     = 8'h55; din[2]     = 8'h00;
        do_reset();
        load_key(1'b0, 8'h0F);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.a_valid = 1'b1;
            bus.a_data  = din[i];
            #1;
            total++;
            if (bus.a_ready !== 1'b1) begin
                bad++;
                $display("FAIL roll_ready[%0d]: got %b want 1", i, bus.a_ready);
            end
            @(posedge clk);
            #1;
            total++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== exp_out[i] || bus.out_src !== 1'b0) begin
                bad++;
                $display("FAIL roll_out[%0d]: got v=%b d=%h s=%b want 1 %h 0",
                         i, bus.out_valid, bus.out_data, bus.out_src, exp_out[i]);
            end
            if (i == 1) begin
                total++;
                if (bus.cnt_a !== 8'd2) begin
                    bad++;
                    $display("FAIL roll_cnt: got %0d want 2", bus.cnt_a);
                end
            end
        end
        @(negedge clk);
        idle_inputs();
        @(posedge clk);
        #1;
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL roll_drain: got out_valid=%b want 0", bus.out_valid);
        end
    endtask

    task automatic test_fair();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.a_valid = 1'b1;
            bus.a_data  = 8'h11;
            bus.b_valid = 1'b1;
            bus.b_data  = 8'h22;
            #1;
            total++;
            if (bus.a_ready !== ((i % 2) == 0) || bus.b_ready !== ((i % 2) == 1)) begin
                bad++;
                $display("FAIL fair_ready[%0d]: got a=%b b=%b want a=%b b=%b",
                         i, bus.a_ready, bus.b_ready, (i % 2) == 0, (i % 2) == 1);
            end
            @(posedge clk);
            #1;
            total++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== (((i % 2) == 0) ? 8'h11 : 8'h22)
                || bus.out_src !== ((i % 2) == 1)) begin
                bad++;
                $display("FAIL fair_out[%0d]: got v=%b d=%h s=%b", i,
                         bus.out_valid, bus.out_data, bus.out_src);
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_backpressure();
        do_reset();
        load_key(1'b0, 8'h0F);
        @(negedge clk);
        bus.a_valid = 1'b1;
        bus.a_data  = 8'h55;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.out_ready = 1'b0;
            #1;
            total++;
            if (bus.a_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_data !== 8'h5A
                || bus.cnt_a !== 8'd1) begin
                bad++;
                $display("FAIL bp_hold[%0d]: got rdy=%b v=%b d=%h cnt=%0d want 0 1 5a 1",
                         i, bus.a_ready, bus.out_valid, bus.out_data, bus.cnt_a);
            end
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        #1;
        total++;
        if (bus.a_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_release_ready: got %b want 1", bus.a_ready);
        end
        @(posedge clk);
        #1;
        total++;
        // key_a still 0x1E after the stall, so 0x55 ^ 0x1E
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h4B || bus.cnt_a !== 8'd2) begin
            bad++;
            $display("FAIL bp_next: got v=%b d=%h cnt=%0d want 1 4b 2",
                     bus.out_valid, bus.out_data, bus.cnt_a);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_key_collision();
        do_reset();
        load_key(1'b0, 8'h81);
        @(negedge clk);
        bus.key_we  = 1'b1;
        bus.key_sel = 1'b0;
        bus.key_in  = 8'hF0;
        bus.a_valid = 1'b1;
        bus.a_data  = 8'h00;
        @(posedge clk);
        #1;
        total++;
        if (bus.out_data !== 8'h81) begin
            bad++;
            $display("FAIL coll_out: got %h want 81", bus.out_data);
        end
        @(negedge clk);
        bus.key_we = 1'b0;
        // Simultaneous write to B while A is granted: both must land.
        bus.key_we  = 1'b1;
        bus.key_sel = 1'b1;
        bus.key_in  = 8'h33;
        @(posedge clk);
        #1;
        total++;
        if (bus.out_data !== 8'hF0) begin
            bad++;
            $display("FAIL coll_key: got %h want f0", bus.out_data);
        end
        @(negedge clk);
        idle_inputs();
        bus.b_valid = 1'b1;
        bus.b_data  = 8'h00;
        @(posedge clk);
        #1;
        total++;
        if (bus.out_data !== 8'h33 || bus.out_src !== 1'b1) begin
            bad++;
            $display("FAIL coll_other: got d=%h s=%b want 33 1", bus.out_data, bus.out_src);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_wrap_reset();
        do_reset();
        load_key(1'b1, 8'h01);
        load_key(1'b0, 8'h77);
        for (int i = 0; i < 257; i++) begin
            @(negedge clk);
            bus.b_valid = 1'b1;
            bus.b_data  = i[7:0];
        end
        @(posedge clk);
        #1;
        total++;
        if (bus.cnt_b !== 8'd1 || bus.out_valid !== 1'b1) begin
            bad++;
            $display("FAIL wrap_cnt: got cnt_b=%0d v=%b want 1 1", bus.cnt_b, bus.out_valid);
        end
        @(negedge clk);
        rst         = 1'b1;
        bus.a_valid = 1'b1;
        bus.a_data  = 8'h11;
        bus.b_valid = 1'b1;
        bus.b_data  = 8'h22;
        #1;
        total++;
        if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b0) begin
            bad++;
            $display("FAIL midrst_ready: got a=%b b=%b want 0 0", bus.a_ready, bus.b_ready);
        end
        @(posedge clk);
        #1;
        total++;
        if (bus.out_valid !== 1'b0 || bus.cnt_a !== 8'd0 || bus.cnt_b !== 8'd0) begin
            bad++;
            $display("FAIL midrst_state: got v=%b cnt_a=%0d cnt_b=%0d want 0 0 0",
                     bus.out_valid, bus.cnt_a, bus.cnt_b);
        end
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            total++;
            if (bus.a_ready !== (i == 0) || bus.b_ready !== (i == 1)) begin
                bad++;
                $display("FAIL midrst_arb[%0d]: got a=%b b=%b", i, bus.a_ready, bus.b_ready);
            end
            @(posedge clk);
            #1;
            total++;
            // Keys back at zero, so plaintext passes through unchanged.
            if (bus.out_data !== ((i == 0) ? 8'h11 : 8'h22) || bus.out_src !== (i == 1)) begin
                bad++;
                $display("FAIL midrst_key[%0d]: got d=%h s=%b", i, bus.out_data, bus.out_src);
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        idle_inputs();
        test_reset();
        test_rolling_key();
        test_fair();
        test_backpressure();
        test_key_collision();
        test_wrap_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
